decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: 8x16 register file with writeback bypass, opcode decode,
// load-use hazard detection with a two-state stall FSM, and the ID/EX pipeline register.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_IFID,
  input  logic [15:0] PC_IFID,
  input  logic [15:0] PC2_IFID,
  input  logic        halt_IFID,
  input  logic        takeBranch_EXMEM,
  input  logic        freeze,
  input  logic        writeEn_WB,
  input  logic [2:0]  writeReg_WB,
  input  logic [15:0] writeData_WB,
  output logic        stallCtrl,
  output logic        startStall,
  output logic [15:0] instr_IDEX,
  output logic [15:0] PC_IDEX,
  output logic [15:0] PC2_IDEX,
  output logic [15:0] rdData1_IDEX,
  output logic [15:0] rdData2_IDEX,
  output logic [2:0]  writeReg_IDEX,
  output logic        regWrite_IDEX,
  output logic        memRead_IDEX,
  output logic        halt_IDEX
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [15:0] BUBBLE_INSTR = 16'h0800;

  state_t      state;
  state_t      state_next;

  logic [15:0] rf [8];

  logic [4:0]  op;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        reg_write;
  logic        mem_read;
  logic        rt_used;
  logic [2:0]  dest;
  logic        hazard;
  logic        load_bubble;

  assign op = instr_IFID[15:11];
  assign rs = instr_IFID[10:8];
  assign rt = instr_IFID[7:5];

  // A register being written back this cycle is forwarded straight to the readers.
  always_comb begin
    rd_data1 = rf[rs];
    rd_data2 = rf[rt];
    if (writeEn_WB && (writeReg_WB == rs)) rd_data1 = writeData_WB;
    if (writeEn_WB && (writeReg_WB == rt)) rd_data2 = writeData_WB;
  end

  always_comb begin
    // NOTE: each signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    reg_write = 1'b1;
    mem_read  = 1'b0;
    rt_used   = 1'b0;
    dest      = instr_IFID[7:5];

    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011,
      5'b00100, 5'b00101, 5'b10000,
      5'b01100, 5'b01101, 5'b01110, 5'b01111: reg_write = 1'b0;
      default:                                reg_write = 1'b1;
    endcase

    case (op)
      5'b11011, 5'b11010: dest = instr_IFID[4:2];
      5'b00110, 5'b00111: dest = 3'd7;
      default:            dest = instr_IFID[7:5];
    endcase

    case (op)
      5'b11011, 5'b11010, 5'b10000, 5'b10011: rt_used = 1'b1;
      default:                                rt_used = 1'b0;
    endcase

    mem_read = (op == 5'b10001);
  end

  // A load in ID/EX feeding either source of the instruction in IF/ID; a flush overrides it.
  assign hazard = memRead_IDEX & regWrite_IDEX
                & ((writeReg_IDEX == rs) | (rt_used & (writeReg_IDEX == rt)))
                & ~takeBranch_EXMEM;

  assign load_bubble = hazard | takeBranch_EXMEM;
  assign stallCtrl   = hazard;
  assign startStall  = hazard & (state == IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hazard) state_next = STALL;
      STALL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (freeze) begin
      state <= state_next;
    end
  end

  // NOTE: the file must read as zero after reset, so it is built from resettable flops
  // rather than a RAM macro, which could not be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (writeEn_WB && freeze) begin
      rf[writeReg_WB] <= writeData_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_IDEX    <= BUBBLE_INSTR;
      PC_IDEX       <= '0;
      PC2_IDEX      <= '0;
      rdData1_IDEX  <= '0;
      rdData2_IDEX  <= '0;
      writeReg_IDEX <= '0;
      regWrite_IDEX <= 1'b0;
      memRead_IDEX  <= 1'b0;
      halt_IDEX     <= 1'b0;
    end else if (freeze) begin
      if (load_bubble) begin
        instr_IDEX    <= BUBBLE_INSTR;
        PC_IDEX       <= '0;
        PC2_IDEX      <= '0;
        rdData1_IDEX  <= '0;
        rdData2_IDEX  <= '0;
        writeReg_IDEX <= '0;
        regWrite_IDEX <= 1'b0;
        memRead_IDEX  <= 1'b0;
        halt_IDEX     <= 1'b0;
      end else begin
        instr_IDEX    <= instr_IFID;
        PC_IDEX       <= PC_IFID;
        PC2_IDEX      <= PC2_IFID;
        rdData1_IDEX  <= rd_data1;
        rdData2_IDEX  <= rd_data2;
        writeReg_IDEX <= dest;
        regWrite_IDEX <= reg_write;
        memRead_IDEX  <= mem_read;
        halt_IDEX     <= halt_IFID;
      end
    end
  end

endmodule
